// File: rtl/pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// pipe_stage_hs
//   Handshaked pipeline register placed between two adjacent core stages.
//   Carries an opaque payload bundle plus its PC across a valid/ready
//   boundary with one cycle of latency. It supports a downstream stall, a
//   synchronous flush, and an optional second (skid) entry that lets
//   in_ready come straight from state flops instead of from out_ready.
//
// Parameters
//   WIDTH    payload bundle width (packed by the instantiating stage)
//   PC_W     PC width
//   SKID_EN  1: two-entry skid buffer, registered in_ready
//            0: single entry, in_ready combinational from out_ready
//   STALL_W  width of the saturating stall counter
//
// Ports
//   clock      core clock, rising edge
//   reset      asynchronous active-high reset, clears all state
//   flush      synchronous kill of all held entries, highest priority
//   in_valid   upstream offers an entry
//   in_ready   this stage accepts an entry this cycle
//   in_data    upstream payload
//   in_pc      upstream PC
//   out_valid  head entry is valid
//   out_ready  downstream accepts the head entry this cycle
//   out_data   head payload
//   out_pc     head PC
//   stall_cnt  cycles spent with out_valid=1 and out_ready=0 (saturating)
// ---------------------------------------------------------------------------
module pipe_stage_hs #(
  parameter int WIDTH   = 128,
  parameter int PC_W    = 64,
  parameter int SKID_EN = 1,
  parameter int STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [PC_W-1:0]    out_pc,
  output logic [STALL_W-1:0] stall_cnt
);

  // State encoding is chosen so that bit 0 is "main entry valid" and bit 1
  // is "skid entry valid". out_valid and in_ready are then plain functions
  // of single state flops, with no decode logic in front of them.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;

  logic [WIDTH-1:0]   main_data_q;
  logic [PC_W-1:0]    main_pc_q;
  logic [WIDTH-1:0]   skid_data_q;
  logic [PC_W-1:0]    skid_pc_q;
  logic [STALL_W-1:0] stall_cnt_q;

  logic main_load_in;
  logic main_load_skid;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // Without the skid entry, an input in ONE (FULL) can only be accepted
  // together with an output, so ST_TWO is unreachable in that build.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            state_d = (SKID_EN != 0) ? ST_TWO : ST_ONE;
          end else if (!in_fire && out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid = main_valid;
    if (SKID_EN != 0) begin
      in_ready = !skid_valid;
    end else begin
      in_ready = !main_valid || out_ready;
    end
  end

  // -------------------------------------------------------------------------
  // Main entry (drives out_*)
  // It takes the input when it is empty or its current entry leaves this
  // cycle; it takes the skid entry when leaving from TWO. Flush blocks every
  // load so a dropped input never lands in a register, but it does not
  // clear the data: out_valid=0 already marks it as a bubble.
  // -------------------------------------------------------------------------
  assign main_load_in   = !flush && in_fire && (!main_valid || out_fire);
  assign main_load_skid = !flush && skid_valid && out_fire;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_data_q <= '0;
      main_pc_q   <= '0;
    end else if (main_load_skid) begin
      main_data_q <= skid_data_q;
      main_pc_q   <= skid_pc_q;
    end else if (main_load_in) begin
      main_data_q <= in_data;
      main_pc_q   <= in_pc;
    end
  end

  assign out_data = main_data_q;
  assign out_pc   = main_pc_q;

  // -------------------------------------------------------------------------
  // Skid entry
  // Filled only when an input arrives while the main entry is stalled.
  // -------------------------------------------------------------------------
  generate
    if (SKID_EN != 0) begin : g_skid
      logic skid_load;

      assign skid_load = !flush && in_fire && main_valid && !out_fire;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          skid_data_q <= '0;
          skid_pc_q   <= '0;
        end else if (skid_load) begin
          skid_data_q <= in_data;
          skid_pc_q   <= in_pc;
        end
      end
    end else begin : g_no_skid
      assign skid_data_q = '0;
      assign skid_pc_q   = '0;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Saturating stall counter; only reset clears it, flush leaves it alone.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (main_valid && !out_ready && (stall_cnt_q != {STALL_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(STALL_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised, handshaked pipeline register for the ysyx_22040931 core. It is the generalised replacement for the fixed-field, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload bundle plus PC across a valid/ready boundary.
- Supports downstream stall, synchronous flush, and an optional second (skid) entry so in_ready can be driven from a flop.
- Sits between any two adjacent stages; the stall counter feeds performance debug.

Parameters:
- WIDTH, 128, payload bundle width in bits (control plus operands, packed by the instantiating stage).
- PC_W, 64, PC width.
- SKID_EN, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational ready.
- STALL_W, 16, width of the saturating stall counter.

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous kill of all held entries; highest priority.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_data  in  WIDTH  upstream payload.
- in_pc  in  PC_W  upstream PC.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry this cycle.
- out_data  out  WIDTH  head payload.
- out_pc  out  PC_W  head PC.
- stall_cnt  out  STALL_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshake:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready at a rising edge.
  - While out_valid=1 and out_ready=0, out_data and out_pc hold stable and out_valid stays 1.
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_pc=0, stall_cnt=0.
  - Skid entry is invalid and zero.
  - in_ready=1.
- Latency: 1 cycle. An entry accepted at edge N is visible on out_* after edge N. There is no combinational path from in_data to out_data.
- SKID_EN=0 (states EMPTY, FULL):
  - in_ready = !out_valid || out_ready. This is a combinational path from out_ready.
  - EMPTY -> FULL on input transfer.
  - FULL stays FULL on simultaneous input and output transfer; the register is reloaded with the new entry.
  - FULL -> EMPTY on output transfer with no input.
- SKID_EN=1 (states EMPTY, ONE, TWO; main entry drives out_*):
  - in_ready = !skid_valid, taken directly from a flop. in_ready=1 in EMPTY and ONE, 0 in TWO.
  - EMPTY + input -> ONE; main is loaded.
  - ONE + input + no output -> TWO; skid is loaded.
  - ONE + input + output -> ONE; main is reloaded with the input.
  - ONE + output only -> EMPTY.
  - TWO + output -> ONE; skid moves to main. No input is accepted in TWO.
  - Order is strictly FIFO. An entry never overtakes another or duplicates.
- flush:
  - At the edge where flush=1, all entries are invalidated and the state goes to EMPTY.
  - Any input offered that cycle is dropped, not stored.
  - Any output transfer in the same cycle still counts as completed downstream.
  - Data registers are not cleared by flush; out_valid=0 marks them as a bubble.
  - Next cycle: out_valid=0 and in_ready=1.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^STALL_W-1 and does not wrap.
  - Cleared only by reset; flush does not clear it.
- Reset asserted mid-transfer: outputs go to reset values immediately, without waiting for a clock edge. Any in-flight entries are lost.
- X safety:
  - in_data and in_pc are ignored when in_valid=0.
  - out_ready is ignored when out_valid=0; stall_cnt does not increment.

Test Plan:
- Reset and streaming: reset asserted between clock edges -> out_valid=0, out_pc=0, in_ready=1 without any clock. Then in_valid=1 with in_pc=0x80000000/04/08 on consecutive cycles and out_ready=1 -> same PCs appear on out_pc one cycle later, back to back, no bubbles.
- Stall with SKID_EN=1: send pc 0x10, 0x14, 0x18 with out_ready=0 -> in_ready drops to 0 after 0x14 is accepted and 0x18 is held upstream. out_pc holds 0x10 and stall_cnt counts 1,2,3… Release out_ready -> drain order is 0x10, 0x14, 0x18.
- SKID_EN=0 stall: out_ready=0 while FULL -> in_ready=0 in the same cycle. Raise out_ready with in_valid=1 -> simultaneous transfer, out_pc is updated on the next cycle.
- Flush: state TWO holding 0x20/0x24, flush=1 with in_valid=1 and pc 0x28 -> next cycle out_valid=0, in_ready=1, and 0x28 never appears on the output.
- Saturation: STALL_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15. A flush then leaves it at 15; a reset clears it to 0.
- Mid-operation reset: reset asserted while in state TWO under a stall -> all outputs go to reset values asynchronously. After release, the first new input appears alone, with no stale entry.
